// File: rtl/id_ex_control_reg_pkg.sv
// Shared types and constants for the ID-stage main decoder and the ID/EX
// control pipeline register of the pipelined MIPS core.
package id_ex_control_reg_pkg;

  localparam int OPW  = 6;
  localparam int AOPW = 2;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;

  // 2'b11 is reserved and never produced by the decoder.
  localparam logic [AOPW-1:0] ALUOP_ADD = 2'b00;
  localparam logic [AOPW-1:0] ALUOP_BR  = 2'b01;
  localparam logic [AOPW-1:0] ALUOP_R   = 2'b10;

  typedef struct packed {
    logic [AOPW-1:0] alu_op;
    logic            reg_dst;
    logic            alu_src;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            reg_write;
    logic            branch;
    logic            branch_ne;
    logic            jump;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  // Full contents of the ID/EX control register.
  typedef struct packed {
    logic           valid;
    ctrl_t          ctrl;
    logic [OPW-1:0] funct;
    logic           illegal;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

  // True when a bundle would both write the register file and store.
  function automatic logic ctrl_write_conflict(input ctrl_t c);
    return c.reg_write & c.mem_write;
  endfunction

endpackage

// File: rtl/id_ex_control_reg_main_decoder.sv
// Combinational MIPS main decoder: opcode in, datapath control bundle and
// an illegal-opcode flag out. Unlisted opcodes decode to an all-zero bundle.
module main_decoder
  import id_ex_control_reg_pkg::*;
(
  input  logic [OPW-1:0] opcode_i,
  output ctrl_t          ctrl_o,
  output logic           illegal_o
);

  always_comb begin
    ctrl_o    = BUBBLE;
    illegal_o = 1'b0;
    unique case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_R;
      end
      OP_LW: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      OP_ADDI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.alu_op = ALUOP_BR;
      end
      OP_BNE: begin
        ctrl_o.branch    = 1'b1;
        ctrl_o.branch_ne = 1'b1;
        ctrl_o.alu_op    = ALUOP_BR;
      end
      OP_J: begin
        ctrl_o.jump   = 1'b1;
        ctrl_o.alu_op = ALUOP_ADD;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_control_reg.sv
// ID/EX control pipeline register: decodes the ID instruction and registers
// the control bundle plus funct into EX, with stall (hold) and flush (bubble).
module id_ex_control_reg
  import id_ex_control_reg_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [31:0]     id_inst,
  input  logic            stall,
  input  logic            flush,
  output logic            ex_valid,
  output logic [AOPW-1:0] ex_alu_op,
  output logic [OPW-1:0]  ex_funct,
  output logic            ex_reg_dst,
  output logic            ex_alu_src,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_reg_write,
  output logic            ex_branch,
  output logic            ex_branch_ne,
  output logic            ex_jump,
  output logic            ex_illegal
);

  ctrl_t  dec_ctrl;
  logic   dec_illegal;
  stage_t stage_q, stage_d;

  // Only opcode and funct fields matter to control; the rest belongs to EX.
  logic unused_inst_bits;
  assign unused_inst_bits = ^id_inst[25:6];

  main_decoder u_main_decoder (
    .opcode_i  (id_inst[31:26]),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

  // Update priority: flush beats stall, stall holds everything (including
  // illegal), an empty ID slot loads a bubble, otherwise load the decode.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = STAGE_BUBBLE;
    end else if (stall) begin
      stage_d = stage_q;
    end else if (!id_valid) begin
      stage_d = STAGE_BUBBLE;
    end else begin
      stage_d.valid   = 1'b1;
      stage_d.ctrl    = dec_ctrl;
      stage_d.funct   = id_inst[5:0];
      stage_d.illegal = dec_illegal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= STAGE_BUBBLE;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign ex_valid      = stage_q.valid;
  assign ex_alu_op     = stage_q.ctrl.alu_op;
  assign ex_funct      = stage_q.funct;
  assign ex_reg_dst    = stage_q.ctrl.reg_dst;
  assign ex_alu_src    = stage_q.ctrl.alu_src;
  assign ex_mem_read   = stage_q.ctrl.mem_read;
  assign ex_mem_write  = stage_q.ctrl.mem_write;
  assign ex_mem_to_reg = stage_q.ctrl.mem_to_reg;
  assign ex_reg_write  = stage_q.ctrl.reg_write;
  assign ex_branch     = stage_q.ctrl.branch;
  assign ex_branch_ne  = stage_q.ctrl.branch_ne;
  assign ex_jump       = stage_q.ctrl.jump;
  assign ex_illegal    = stage_q.illegal;

  a_alu_op_never_reserved: assert property (
    @(posedge clk) disable iff (rst) stage_q.ctrl.alu_op != 2'b11);

  a_no_write_and_store: assert property (
    @(posedge clk) disable iff (rst) !ctrl_write_conflict(stage_q.ctrl));

  a_illegal_implies_valid: assert property (
    @(posedge clk) disable iff (rst) stage_q.illegal |-> stage_q.valid);

endmodule

// File: tb/tb_id_ex_control_reg.sv
// Self-checking bench for id_ex_control_reg: directed scenarios plus random
// traffic against a table-driven reference model of the ID/EX register.
module tb_id_ex_control_reg;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_inst;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [1:0]  ex_alu_op;
  logic [5:0]  ex_funct;
  logic        ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write;
  logic        ex_mem_to_reg, ex_reg_write, ex_branch, ex_branch_ne;
  logic        ex_jump, ex_illegal;

  int checks = 0;
  int errors = 0;

  // Output vector: {valid, alu_op[1:0], funct[5:0], reg_dst, alu_src,
  // mem_read, mem_write, mem_to_reg, reg_write, branch, branch_ne, jump, illegal}
  logic [18:0] exp_q[$];
  logic [18:0] cur_exp;
  logic [18:0] pre_obs;
  logic [18:0] prev_exp;

  // Opcode -> {alu_op[1:0], reg_dst, alu_src, mem_read, mem_write,
  // mem_to_reg, reg_write, branch, branch_ne, jump}
  logic [10:0] ctrl_tab [logic [5:0]];

  id_ex_control_reg dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_inst       (id_inst),
    .stall         (stall),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .ex_alu_op     (ex_alu_op),
    .ex_funct      (ex_funct),
    .ex_reg_dst    (ex_reg_dst),
    .ex_alu_src    (ex_alu_src),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_reg_write  (ex_reg_write),
    .ex_branch     (ex_branch),
    .ex_branch_ne  (ex_branch_ne),
    .ex_jump       (ex_jump),
    .ex_illegal    (ex_illegal)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] obs();
    return {ex_valid, ex_alu_op, ex_funct, ex_reg_dst, ex_alu_src, ex_mem_read,
            ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_branch, ex_branch_ne,
            ex_jump, ex_illegal};
  endfunction

  function automatic logic [18:0] model_next(input logic [18:0] prev, input logic v,
                                             input logic [31:0] inst,
                                             input logic st, input logic fl);
    logic [5:0]  op;
    logic [10:0] t;
    op = inst[31:26];
    if (fl) return '0;
    if (st) return prev;
    if (!v) return '0;
    if (ctrl_tab.exists(op)) begin
      t = ctrl_tab[op];
      return {1'b1, t[10:9], inst[5:0], t[8:0], 1'b0};
    end
    return {1'b1, 2'b00, inst[5:0], 9'b0, 1'b1};
  endfunction

  // Driver: called one time unit after a rising edge. Captures outputs just
  // before the next edge, then queues the model's expectation for that edge.
  task automatic drive(input logic v, input logic [31:0] inst,
                       input logic st, input logic fl);
    id_valid = v;
    id_inst  = inst;
    stall    = st;
    flush    = fl;
    #3;
    pre_obs  = obs();
    prev_exp = cur_exp;
    cur_exp  = model_next(cur_exp, v, inst, st, fl);
    exp_q.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [18:0] e;
    rst = 1'b1;
    id_valid = 1'b0; id_inst = '0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== 19'd0) begin
      errors++; $display("FAIL reset_init: got %h expected %h", obs(), 19'd0);
    end
    // Reset must win over stall/flush and a valid instruction at the edge.
    id_valid = 1'b1; id_inst = 32'h00851020; stall = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs() !== 19'd0) begin
      errors++; $display("FAIL reset_hold: got %h expected %h", obs(), 19'd0);
    end
    rst = 1'b0;
    cur_exp = '0;
    exp_q.delete();
    drive(1'b1, 32'h00851020, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL reset_first_update: got %h expected %h", obs(), e);
    end
    // Asynchronous assertion mid-cycle: clears before any clock edge.
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== 19'd0) begin
      errors++; $display("FAIL reset_async: got %h expected %h", obs(), 19'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    cur_exp = '0;
  endtask

  task automatic test_rtype();
    logic [18:0] e;
    drive(1'b1, 32'h00851020, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== 19'b1_10_100000_1_0_0_0_0_1_0_0_0_0) begin
      errors++;
      $display("FAIL rtype_add: got %h expected %h", obs(), 19'b1_10_100000_1_0_0_0_0_1_0_0_0_0);
    end
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL rtype_model: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] insts [4];
    logic [18:0] e;
    insts = '{32'h8C820004, 32'hAC820004, 32'h10850003, 32'h14850003};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, insts[i], 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL back_to_back_%0d: got %h expected %h", i, obs(), e);
      end
    end
    // Last entry is bne: alu_op=01, branch=1, branch_ne=1.
    checks++;
    if ({ex_alu_op, ex_branch, ex_branch_ne} !== 4'b0111) begin
      errors++;
      $display("FAIL bne_fields: got %b expected %b", {ex_alu_op, ex_branch, ex_branch_ne}, 4'b0111);
    end
  endtask

  task automatic test_stall();
    logic [18:0] e;
    logic [18:0] addi_exp;
    drive(1'b1, 32'h20820005, 1'b0, 1'b0);
    addi_exp = exp_q.pop_front();
    checks++;
    if (obs() !== addi_exp) begin
      errors++; $display("FAIL stall_load_addi: got %h expected %h", obs(), addi_exp);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h08000010, 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e || obs() !== addi_exp) begin
        errors++; $display("FAIL stall_hold_%0d: got %h expected %h", i, obs(), addi_exp);
      end
    end
    drive(1'b1, 32'h08000010, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e || ex_jump !== 1'b1) begin
      errors++; $display("FAIL stall_release_j: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h00851020, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    drive(1'b1, 32'h00A62022, 1'b1, 1'b1);
    void'(exp_q.pop_front());
    checks++;
    if (obs() !== 19'd0) begin
      errors++; $display("FAIL flush_over_stall: got %h expected %h", obs(), 19'd0);
    end
  endtask

  task automatic test_illegal();
    logic [18:0] e;
    drive(1'b1, 32'hFC000025, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== 19'b1_00_100101_000000000_1 || obs() !== e) begin
      errors++; $display("FAIL illegal_set: got %h expected %h", obs(), e);
    end
    drive(1'b1, 32'h00851020, 1'b1, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (ex_illegal !== 1'b1 || obs() !== e) begin
      errors++; $display("FAIL illegal_stall_hold: got %h expected %h", obs(), e);
    end
    drive(1'b1, 32'h00851020, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (ex_illegal !== 1'b0 || obs() !== e) begin
      errors++; $display("FAIL illegal_clear: got %h expected %h", obs(), e);
    end
    drive(1'b0, 32'hFC000025, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== 19'd0 || obs() !== e) begin
      errors++; $display("FAIL illegal_invalid_slot: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_random();
    logic [5:0]  ops [8];
    logic [31:0] r;
    logic [5:0]  op;
    logic        v, st, fl;
    logic [18:0] e;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b001000,
            6'b000100, 6'b000101, 6'b000010, 6'b111111};
    for (int i = 0; i < 300; i++) begin
      r  = $urandom();
      op = ($urandom_range(0, 4) == 0) ? r[31:26] : ops[$urandom_range(0, 7)];
      v  = ($urandom_range(0, 5) != 0);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      drive(v, {op, r[25:0]}, st, fl);
      e = exp_q.pop_front();
      checks++;
      if (pre_obs !== prev_exp) begin
        errors++; $display("FAIL rand_pre_edge_%0d: got %h expected %h", i, pre_obs, prev_exp);
      end
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL rand_post_edge_%0d: got %h expected %h", i, obs(), e);
      end
      checks++;
      if (ex_alu_op === 2'b11 || (ex_reg_write && ex_mem_write)) begin
        errors++;
        $display("FAIL rand_invariant_%0d: got alu_op=%b rw=%b mw=%b expected alu_op!=11 and not rw&mw",
                 i, ex_alu_op, ex_reg_write, ex_mem_write);
      end
    end
  endtask

  initial begin
    ctrl_tab[6'b000000] = 11'b10_1_0_0_0_0_1_0_0_0;
    ctrl_tab[6'b100011] = 11'b00_0_1_1_0_1_1_0_0_0;
    ctrl_tab[6'b101011] = 11'b00_0_1_0_1_0_0_0_0_0;
    ctrl_tab[6'b001000] = 11'b00_0_1_0_0_0_1_0_0_0;
    ctrl_tab[6'b000100] = 11'b01_0_0_0_0_0_0_1_0_0;
    ctrl_tab[6'b000101] = 11'b01_0_0_0_0_0_0_1_1_0;
    ctrl_tab[6'b000010] = 11'b00_0_0_0_0_0_0_0_0_1;
    cur_exp = '0;
    prev_exp = '0;
    pre_obs = '0;

    test_reset();
    test_rtype();
    test_back_to_back();
    test_stall();
    test_flush();
    test_illegal();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_control_reg.md
Name: id_ex_control_reg

Overview:
- ID-stage main decoder plus the ID/EX control pipeline register for the pipelined MIPS core.
- Decodes the 6-bit opcode into datapath control and the 2-bit ALU operation class.
- Registers these with funct[5:0] into the EX stage, where the ALU control PLA converts alu_op/funct into the 3-bit ALU select.
- Provides stall (hold) and flush (bubble) handling so hazard and branch logic can freeze or squash the stage.

Parameters:
- OPW, 6, opcode and funct field width
- AOPW, 2, ALU operation class width (00 add, 01 branch-subtract, 10 R-type, 11 reserved/never driven)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction this cycle
- id_inst  in  32  instruction word from the IF/ID register
- stall  in  1  hazard unit: hold the ID/EX contents
- flush  in  1  branch/jump resolution: squash the ID/EX contents
- ex_valid  out  1  ID/EX holds a live instruction
- ex_alu_op  out  2  ALU operation class to the ALU control unit
- ex_funct  out  6  id_inst[5:0], registered
- ex_reg_dst  out  1  write-back register select: rd when 1, rt when 0
- ex_alu_src  out  1  ALU B operand source: immediate when 1
- ex_mem_read  out  1  load
- ex_mem_write  out  1  store
- ex_mem_to_reg  out  1  write-back source is memory
- ex_reg_write  out  1  register file write enable
- ex_branch  out  1  beq/bne
- ex_branch_ne  out  1  bne, qualifying ex_branch
- ex_jump  out  1  j
- ex_illegal  out  1  unsupported opcode seen; one-entry pulse

Behaviour:
- Decode is combinational from id_inst[31:26]. All fields not listed for an opcode are 0.
  - 000000 R-type: reg_dst=1, reg_write=1, alu_op=10
  - 100011 lw: alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, alu_op=00
  - 101011 sw: alu_src=1, mem_write=1, alu_op=00
  - 001000 addi: alu_src=1, reg_write=1, alu_op=00
  - 000100 beq: branch=1, alu_op=01
  - 000101 bne: branch=1, branch_ne=1, alu_op=01
  - 000010 j: jump=1, alu_op=00
  - Any other opcode: all controls 0, illegal=1
- Registered update, evaluated in priority order on each rising clk:
  - flush=1: load a bubble, regardless of stall.
  - stall=1: hold every output unchanged, including ex_illegal.
  - id_valid=0: load a bubble.
  - Otherwise: load the decoded controls, ex_funct=id_inst[5:0], ex_valid=1.
- A bubble is: ex_valid=0, all controls 0, ex_alu_op=00, ex_funct=000000, ex_illegal=0.
- ex_illegal:
  - Asserts only when a real update loads an illegal opcode with id_valid=1; ex_valid=1 in that same entry.
  - Clears on the next non-stalled update.
- Latency: exactly one cycle from ID to outputs. No combinational path from inputs to outputs.
- Reset: rst=1 forces the bubble state immediately, without waiting for clk, and holds it while asserted.
  - Reset mid-stall or mid-flush: reset wins.
  - First update happens on the first rising clk after rst deasserts.
- ex_alu_op is never 11.
- ex_reg_write=1 and ex_mem_write=1 are never both asserted.
- ex_funct is passed through for every valid opcode. The ALU control unit ignores it unless alu_op=10; for sll, funct 000000 is passed unchanged.

Decomposition:
- Shared package:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE, OP_J
  - ALU op class constants: ALUOP_ADD=00, ALUOP_BR=01, ALUOP_R=10
  - a packed control-bundle type and a BUBBLE constant
- One sub-module, main_decoder: purely combinational, opcode in, control bundle plus illegal out. The top holds only the priority mux and the registers.

Test Plan:
- Reset asserted asynchronously between clock edges with ex_valid=1 -> all outputs 0 within the same cycle, before the next clk edge.
- id_inst=0x00851020 (add $2,$4,$5), id_valid=1 -> next cycle: ex_valid=1, ex_alu_op=10, ex_funct=100000, ex_reg_dst=1, ex_reg_write=1, all others 0.
- Back-to-back lw 0x8C820004, sw 0xAC820004, beq 0x10850003, bne 0x14850003 -> successive cycles show:
  - lw: alu_op=00, mem_read=1, mem_to_reg=1
  - sw: mem_write=1, reg_write=0
  - beq: alu_op=01, branch=1, branch_ne=0
  - bne: alu_op=01, branch_ne=1
- Load addi 0x20820005, then stall=1 for 3 cycles while id_inst changes to a j -> outputs stay addi (alu_src=1, reg_write=1, alu_op=00) for all 3 cycles, then become j (jump=1) once stall drops.
- stall=1 and flush=1 together with a valid R-type -> next cycle is a bubble (ex_valid=0, all 0).
- id_inst opcode 111111, id_valid=1 -> ex_illegal=1, ex_valid=1, all controls 0. Next unstalled cycle with a valid opcode -> ex_illegal=0. Same opcode with id_valid=0 -> ex_illegal stays 0.
